// File: rtl/serial_word_receiver.sv
// rtl/serial_word_receiver.sv - framed serial bit stream to WIDTH-bit word with valid/ready holding register
// Define PARITY_CHECK_EN to append one even-parity bit per frame and flag it on parity_err.
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             Clr_b,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] A_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             sync_err,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef PARITY_CHECK_EN
    , S_PARITY
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] w_sr_first;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic             w_sync;
  logic [WIDTH-1:0] r_apar;
  logic             r_out_valid;
  logic             r_overrun;
  logic             r_sync_err;
`ifdef PARITY_CHECK_EN
  logic             w_par;
  logic             r_parity_err;
`endif

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] sr, input logic b);
    if (MSB_FIRST != 0)
      return {sr[WIDTH-2:0], b};
    else
      return {b, sr[WIDTH-1:1]};
  endfunction

  assign w_sr_shift = f_shift(r_sr, ser_in);
  // A (re)started frame shifts into an empty register so no stale bits survive.
  assign w_sr_first = f_shift('0, ser_in);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_sync      = 1'b0;
    w_complete  = 1'b0;
    w_word      = w_sr_shift;
`ifdef PARITY_CHECK_EN
    w_par       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (ser_valid && frame_start) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = CW'(1);
          w_sr_nxt    = w_sr_first;
        end
      end
      S_SHIFT: begin
        if (ser_valid && frame_start) begin
          w_sync    = 1'b1;
          w_cnt_nxt = CW'(1);
          w_sr_nxt  = w_sr_first;
        end else if (ser_valid) begin
          w_sr_nxt  = w_sr_shift;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_IDLE;
            w_complete  = 1'b1;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        if (ser_valid && frame_start) begin
          w_sync      = 1'b1;
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = CW'(1);
          w_sr_nxt    = w_sr_first;
        end else if (ser_valid) begin
          w_state_nxt = S_IDLE;
          w_complete  = 1'b1;
          w_word      = r_sr;
          w_par       = ^{r_sr, ser_in};
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Clr_b) begin
    if (!Clr_b) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sr       <= w_sr_nxt;
      r_sync_err <= w_sync;
    end
  end

  // Holding register: a completing word may replace one being consumed on the same edge.
  always_ff @(posedge CLK or negedge Clr_b) begin
    if (!Clr_b) begin
      r_apar       <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_out_valid || out_ready) begin
          r_apar       <= w_word;
          r_out_valid  <= 1'b1;
`ifdef PARITY_CHECK_EN
          r_parity_err <= w_par;
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign A_par     = r_apar;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;
  assign sync_err  = r_sync_err;
`ifdef PARITY_CHECK_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb/tb_serial_word_receiver.sv - randomized and directed check of serial_word_receiver against a bit-queue model
// Two instances (MSB_FIRST=1 and 0) share one stimulus stream.
module tb_serial_word_receiver;
  localparam int W = 4;
`ifdef PARITY_CHECK_EN
  localparam bit PAR  = 1'b1;
`else
  localparam bit PAR  = 1'b0;
`endif
  localparam int FLEN = W + (PAR ? 1 : 0);

  logic         CLK = 1'b0;
  logic         Clr_b = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_m, a_l;
  logic         v_m, v_l, b_m, b_l, o_m, o_l, s_m, s_l, p_m, p_l;

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .CLK(CLK), .Clr_b(Clr_b), .ser_in(ser_in), .ser_valid(ser_valid),
    .frame_start(frame_start), .A_par(a_m), .out_valid(v_m), .out_ready(out_ready),
    .busy(b_m), .overrun(o_m), .sync_err(s_m), .parity_err(p_m)
  );

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .CLK(CLK), .Clr_b(Clr_b), .ser_in(ser_in), .ser_valid(ser_valid),
    .frame_start(frame_start), .A_par(a_l), .out_valid(v_l), .out_ready(out_ready),
    .busy(b_l), .overrun(o_l), .sync_err(s_l), .parity_err(p_l)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr    = 0;
  int n_sync   = 0;

  bit           m_bits[$];
  logic         m_valid;
  logic [W-1:0] m_word_m, m_word_l;
  logic         m_par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_valid  = 1'b0;
    m_word_m = '0;
    m_word_l = '0;
    m_par    = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic step(input logic sv, input logic si, input logic fs, input logic rdy);
    logic         cmp, e_ovr, e_sync, p;
    logic [W-1:0] wm, wl;
    ser_valid = sv; ser_in = si; frame_start = fs; out_ready = rdy;
    cmp = 1'b0; e_ovr = 1'b0; e_sync = 1'b0;
    wm = '0; wl = '0; p = 1'b0;
    if (Clr_b) begin
      if (sv && fs) begin
        if (m_bits.size() != 0) e_sync = 1'b1;
        m_bits.delete();
        m_bits.push_back(si);
      end else if (sv && m_bits.size() != 0) begin
        m_bits.push_back(si);
        if (m_bits.size() == FLEN) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = m_bits[i];
            wl[i]     = m_bits[i];
          end
          for (int i = 0; i < FLEN; i++) p ^= m_bits[i];
          cmp = 1'b1;
          m_bits.delete();
        end
      end
      if (cmp) begin
        if (!m_valid || rdy) begin
          m_valid  = 1'b1;
          m_word_m = wm;
          m_word_l = wl;
          m_par    = PAR ? p : 1'b0;
        end else begin
          e_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    if (o_m) n_ovr++;
    if (s_m) n_sync++;
    check("apar_msb", 32'(a_m), 32'(m_word_m));
    check("apar_lsb", 32'(a_l), 32'(m_word_l));
    check("valid_msb", 32'(v_m), 32'(m_valid));
    check("valid_lsb", 32'(v_l), 32'(m_valid));
    check("busy_msb", 32'(b_m), 32'(m_bits.size() != 0));
    check("busy_lsb", 32'(b_l), 32'(m_bits.size() != 0));
    check("overrun", 32'({o_m, o_l}), 32'({e_ovr, e_ovr}));
    check("sync_err", 32'({s_m, s_l}), 32'({e_sync, e_sync}));
    check("parity_err", 32'({p_m, p_l}), 32'({m_par, m_par}));
  endtask

  // Sends v[W-1] first; rdy_last is the ready level on the frame's final bit.
  task automatic send_frame(input logic [W-1:0] v, input logic par, input int gap,
                            input logic rdy, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, rdy);
`ifdef PARITY_CHECK_EN
      step(1'b1, v[i], i == W - 1, rdy);
`else
      step(1'b1, v[i], i == W - 1, (i == 0) ? rdy_last : rdy);
`endif
    end
`ifdef PARITY_CHECK_EN
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, rdy);
    step(1'b1, par, 1'b0, rdy_last);
`else
    if (par) n_checks += 0;
`endif
  endtask

  initial begin
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    check("rst_apar", 32'({a_m, a_l}), 32'h0);
    check("rst_flags", 32'({v_m, v_l, b_m, b_l, o_m, o_l, s_m, s_l, p_m, p_l}), 32'h0);
    Clr_b = 1'b1;

    // Bits 1,0,1,1 with ready high
    send_frame(4'b1011, 1'b1, 0, 1'b1, 1'b1);
    check("t1_msb_word", 32'(a_m), 32'hB);
    check("t1_lsb_word", 32'(a_l), 32'hD);
    check("t1_valid", 32'(v_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_valid_drop", 32'(v_m), 32'h0);

    // Same bits with 3-cycle gaps
    send_frame(4'b1011, 1'b1, 3, 1'b1, 1'b1);
    check("t2_lsb_word", 32'(a_l), 32'hD);
    check("t2_msb_word", 32'(a_m), 32'hB);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Stalled consumer: second word dropped, then load on the ready edge
    n_ovr = 0;
    send_frame(4'hA, 1'b0, 0, 1'b0, 1'b0);
    send_frame(4'h5, 1'b0, 0, 1'b0, 1'b0);
    check("t3_overrun_cnt", 32'(n_ovr), 32'd1);
    check("t3_hold_msb", 32'(a_m), 32'hA);
    check("t3_hold_lsb", 32'(a_l), 32'h5);
    send_frame(4'h3, 1'b0, 0, 1'b0, 1'b1);
    check("t3_load_msb", 32'(a_m), 32'h3);
    check("t3_load_lsb", 32'(a_l), 32'hC);
    check("t3_no_bubble", 32'(v_m), 32'h1);
    check("t3_overrun_cnt2", 32'(n_ovr), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Restart mid-frame
    n_sync = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(4'b0110, 1'b0, 0, 1'b1, 1'b1);
    check("t4_sync_cnt", 32'(n_sync), 32'd1);
    check("t4_word", 32'({a_m, a_l}), 32'h66);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    Clr_b = 1'b0;
    model_reset();
    #1;
    check("t5_busy_in_rst", 32'({b_m, b_l}), 32'h0);
    check("t5_apar_in_rst", 32'({a_m, a_l}), 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    Clr_b = 1'b1;
    send_frame(4'h3, 1'b0, 0, 1'b1, 1'b1);
    check("t5_word_msb", 32'(a_m), 32'h3);
    check("t5_word_lsb", 32'(a_l), 32'hC);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
    send_frame(4'b1011, 1'b1, 0, 1'b1, 1'b1);
    check("t6_parity_ok", 32'(p_m), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'b1011, 1'b0, 0, 1'b1, 1'b1);
    check("t6_parity_bad", 32'(p_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        Clr_b = 1'b0;
        model_reset();
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        Clr_b = 1'b1;
      end else begin
        step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
